// File: rtl/posit_pkg.sv
// Shared posit encoder constants and the regime-field mapping.
package posit_pkg;
  localparam int N  = 10;
  localparam int ES = 4;
  localparam int RG = 2;
  localparam int F  = N - ES - RG - 1;
  localparam int MW = 8;
  localparam int SW = RG + ES + 1;

  localparam logic [N-1:0] MAXPOS_MAG = {2'b00, {(N-2){1'b1}}};
  localparam logic [N-1:0] NAR        = {1'b1, {(N-1){1'b0}}};

  // The regime field is the upper scale bits with the MSB flipped (00->10, 11->01).
  function automatic logic [RG-1:0] regime_map(input logic [RG-1:0] r);
    return {~r[RG-1], r[RG-2:0]};
  endfunction
endpackage

// File: rtl/posit_round_rne.sv
// Combinational scale/fraction increment; round-to-nearest-even when POSIT_ENC_RNE_EN
// is defined, plain truncation otherwise.
module posit_round_rne
  import posit_pkg::*;
(
  input  logic [F-1:0]    frac_i,
  input  logic            guard_i,
  input  logic            sticky_i,
  input  logic [SW-1:0]   scale_i,
  output logic [SW+F-1:0] sum_o
);

  logic rnd;

`ifdef POSIT_ENC_RNE_EN
  function automatic logic rne_inc(input logic g, input logic s, input logic lsb);
    return g & (s | lsb);
  endfunction

  assign rnd = rne_inc(guard_i, sticky_i, frac_i[0]);
`else
  logic unused_gs;
  assign unused_gs = guard_i | sticky_i;
  assign rnd       = 1'b0;
`endif

  // A fraction carry ripples straight into the scale, leaving the fraction cleared.
  assign sum_o = {scale_i, frac_i} + {{(SW+F-1){1'b0}}, rnd};

endmodule

// File: rtl/posit_encode_pipe.sv
// Two-stage posit encoder with valid/ready handshake and maxpos saturation.
// Optional build macro: POSIT_ENC_RNE_EN (round-to-nearest-even; truncation when undefined).
module posit_encode_pipe
  import posit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [SW-1:0] in_scale,
  input  logic [MW-1:0] in_mant,
  input  logic          in_sticky,
  input  logic          in_zero,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic          out_zero,
  output logic          out_inf,
  output logic          out_sat
);

  logic en;

  logic [F-1:0]    frac_p0;
  logic            guard_p0;
  logic            sticky_p0;
  logic [SW+F-1:0] sum_p0;

  logic            vld_p1_q;
  logic [SW+F-1:0] sum_p1_q;
  logic            sign_p1_q;
  logic            zero_p1_q;
  logic            inf_p1_q;

  logic [N-1:0]    mag_p1;
  logic            sat_p1;
  logic [N-2:0]    neg_p1;
  logic [N-1:0]    posit_d;
  logic            sat_d;
  logic            zero_d;
  logic            inf_d;

  logic            vld_p2_q;
  logic [N-1:0]    posit_q;
  logic            sat_q;
  logic            zero_q;
  logic            inf_q;

  // Overflowed sums clamp to maxpos; otherwise split the sum into posit fields.
  function automatic logic [N:0] encode_mag(input logic [SW+F-1:0] s);
    if (s[SW+F-1]) return {1'b1, MAXPOS_MAG};
    return {1'b0, 1'b0, regime_map(s[SW+F-2 -: RG]), s[F+ES-1 -: ES], s[F-1:0]};
  endfunction

  assign en       = !vld_p2_q | out_ready;
  assign in_ready = en;

  // ---- stage 0 -> 1: field extraction and rounding increment ----
  assign frac_p0 = in_mant[MW-2 -: F];

`ifdef POSIT_ENC_RNE_EN
  assign guard_p0  = in_mant[MW-2-F];
  assign sticky_p0 = (|in_mant[MW-3-F:0]) | in_sticky;
`else
  logic unused_lsbs;
  assign unused_lsbs = ^{in_mant[MW-2-F:0], in_sticky};
  assign guard_p0    = 1'b0;
  assign sticky_p0   = 1'b0;
`endif

  posit_round_rne u_round (
    .frac_i   (frac_p0),
    .guard_i  (guard_p0),
    .sticky_i (sticky_p0),
    .scale_i  (in_scale),
    .sum_o    (sum_p0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      sum_p1_q  <= sum_p0;
      sign_p1_q <= in_sign;
      zero_p1_q <= in_zero;
      inf_p1_q  <= in_inf;
    end
  end

  // ---- stage 1 -> 2: saturation, regime mapping, sign and specials ----
  always_comb begin
    {sat_p1, mag_p1} = encode_mag(sum_p1_q);
    neg_p1  = ~mag_p1[N-2:0] + {{(N-2){1'b0}}, 1'b1};
    posit_d = sign_p1_q ? {1'b1, neg_p1} : mag_p1;
    sat_d   = sat_p1;
    zero_d  = 1'b0;
    inf_d   = 1'b0;
    if (inf_p1_q) begin
      posit_d = NAR;
      sat_d   = 1'b0;
      inf_d   = 1'b1;
    end else if (zero_p1_q) begin
      posit_d = '0;
      sat_d   = 1'b0;
      zero_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q <= 1'b0;
      posit_q  <= '0;
      sat_q    <= 1'b0;
      zero_q   <= 1'b0;
      inf_q    <= 1'b0;
    end else if (en) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        posit_q <= posit_d;
        sat_q   <= sat_d;
        zero_q  <= zero_d;
        inf_q   <= inf_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign out_posit = posit_q;
  assign out_sat   = sat_q;
  assign out_zero  = zero_q;
  assign out_inf   = inf_q;

endmodule
